// File: rtl/ex_stage_md.sv
// MIPS execute stage: logic/shift/move result select plus an iterative
// restoring DIV/DIVU unit that owns HI/LO and stalls the pipeline while busy.
module ex_stage_md #(
  parameter int WIDTH    = 32,
  parameter int DIV_ITER = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       aluop_i,
  input  logic [2:0]       alusel_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic [4:0]       wd_i,
  input  logic             wreg_i,
  output logic [WIDTH-1:0] ex_wreg_data,
  output logic             ex_we,
  output logic [4:0]       ex_wreg_addr,
  output logic             stallreq,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;

  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;

  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div, is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed = (aluop_i == OP_DIV);
  assign a_neg     = is_signed & reg1_i[WIDTH-1];
  assign b_neg     = is_signed & reg2_i[WIDTH-1];
  assign a_mag     = a_neg ? -reg1_i : reg1_i;
  assign b_mag     = b_neg ? -reg2_i : reg2_i;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. Remainder stays below the divisor, so
  // the low WIDTH bits of the difference are exact whenever no borrow occurs.
  logic [WIDTH:0]   step_sh;
  logic             step_borrow;
  logic [WIDTH-1:0] step_diff;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  assign step_sh     = {rem_q, quo_q[WIDTH-1]};
  assign step_borrow = (step_sh < {1'b0, dvs_q});
  assign step_diff   = step_sh[WIDTH-1:0] - dvs_q;
  assign step_rem    = step_borrow ? step_sh[WIDTH-1:0] : step_diff;
  assign step_quo    = {quo_q[WIDTH-2:0], ~step_borrow};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (is_div) state_d = (reg2_i == '0) ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          cnt_d  = '0;
          dvs_d  = b_mag;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (reg2_i == '0) begin
            dz_d  = 1'b1;
            rem_d = reg1_i;
            quo_d = '1;
          end else begin
            dz_d  = 1'b0;
            rem_d = '0;
            quo_d = a_mag;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
      end
      S_DONE: begin
        // Divide-by-zero results were preloaded raw and bypass the sign fix.
        hi_d = (!dz_q && rneg_q) ? -rem_q : rem_q;
        lo_d = (!dz_q && qneg_q) ? -quo_q : quo_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    stallreq = 1'b0;
    case (state_q)
      S_IDLE:  stallreq = is_div;
      S_RUN:   stallreq = 1'b1;
      default: stallreq = 1'b0;
    endcase
  end

  logic [WIDTH-1:0] logic_res, shift_res, move_res;

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
      OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
      OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    case (aluop_i)
      OP_MFHI: move_res = hi_q;
      OP_MFLO: move_res = lo_q;
      default: move_res = '0;
    endcase
  end

  always_comb begin
    ex_wreg_data = '0;
    case (alusel_i)
      SEL_LOGIC: ex_wreg_data = logic_res;
      SEL_SHIFT: ex_wreg_data = shift_res;
      SEL_MOVE:  ex_wreg_data = move_res;
      default:   ex_wreg_data = '0;
    endcase
  end

  assign ex_we        = wreg_i & ~stallreq & ~is_div;
  assign ex_wreg_addr = wd_i;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the decoded operation latched by the ID/EX register: aluop, alusel, two 32-bit operands, destination address and write enable.
- Produces the write-back triple consumed by the EX/MEM register. The same triple feeds the decoder's EX forwarding inputs in the same cycle.
- Adds logic, shift and HI/LO move results, plus a multi-cycle iterative DIV/DIVU unit. The divider owns the HI/LO registers and raises a pipeline stall while it runs.

Parameters:
WIDTH, 32, datapath and register width (only 32 supported).
DIV_ITER, 32, restoring-division iterations (must equal WIDTH).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-low (0 = reset).
aluop_i  in  8  operation code.
alusel_i  in  3  result class.
reg1_i  in  32  source operand 1 (rs or immediate).
reg2_i  in  32  source operand 2 (rt or immediate).
wd_i  in  5  destination register address.
wreg_i  in  1  destination write enable.
ex_wreg_data  out  32  result to EX/MEM and ID forwarding.
ex_we  out  1  write enable to EX/MEM and ID forwarding.
ex_wreg_addr  out  5  destination address.
stallreq  out  1  1 = hold PC, IF/ID and ID/EX; EX/MEM receives a bubble.
hi_o  out  32  current HI register.
lo_o  out  32  current LO register.

Behaviour:
- Opcodes:
  - aluop: OR=8'h25, AND=8'h24, XOR=8'h26, NOR=8'h27, SLL=8'h7C, SRL=8'h02, SRA=8'h03, DIV=8'h1A, DIVU=8'h1B, MFHI=8'h10, MFLO=8'h12, NOP=8'h00.
  - alusel: NOP=0, LOGIC=1, SHIFT=2, MOVE=3.
- Logic ops: bitwise on reg1_i, reg2_i.
- Shifts: shift reg2_i by reg1_i[4:0]. SRA replicates reg2_i[31].
- MFHI/MFLO: return current hi_o/lo_o.
- Result select (combinational, 0 latency):
  - ex_wreg_data is chosen by alusel_i; NOP/unknown class gives 0.
  - ex_wreg_addr = wd_i.
  - ex_we = wreg_i, except forced 0 while stallreq=1 and for DIV/DIVU.
- Divider FSM, states IDLE, RUN, DONE:
  - IDLE:
    - If aluop_i is DIV/DIVU: stallreq=1 (combinational); capture operands at the edge.
    - Divisor nonzero: go to RUN with counter=0.
    - Divisor zero: go to DONE, result HI=reg1_i, LO=32'hFFFFFFFF.
  - RUN:
    - stallreq=1; one restoring shift-subtract step per edge on magnitudes.
    - DIV takes absolute values of both operands; DIVU uses them raw.
    - After the step with counter=31, go to DONE.
  - DONE:
    - stallreq=0.
    - Sign fix for DIV: quotient negated iff operand signs differ; remainder takes the dividend's sign.
    - At the edge: HI<=remainder, LO<=quotient, go to IDLE.
    - Must not re-trigger on the still-present DIV opcode; the pipeline advances on this edge.
- Latency: nonzero divide stalls 33 cycles (1 IDLE + 32 RUN). Divide-by-zero stalls 1 cycle. HI/LO are valid from the cycle after DONE.
- Back-to-back DIV: the second starts normally from IDLE.
- MFHI immediately after DIV reads the new HI.
- Operands are captured internally, so ID/EX input changes during RUN are ignored.
- Signed edge case: 0x80000000 / -1 gives LO=0x80000000, HI=0 (wrap, no trap).
- Reset (rst=0 at an edge, any state including mid-RUN): state=IDLE, counter=0, HI=LO=0, partial result discarded. stallreq=0 from the following cycle. Combinational outputs still follow inputs.

Test Plan:
1. OR: aluop=25, alusel=1, reg1=0x00001100, reg2=0x00000020, wd=3, wreg=1 -> same cycle ex_wreg_data=0x00001120, ex_we=1, ex_wreg_addr=3, stallreq=0.
2. SRA: reg1=4, reg2=0x80000F00 -> 0xF80000F0. SRL same operands -> 0x080000F0.
3. DIV: reg1=0xFFFFFFF9 (-7), reg2=2 -> stallreq high exactly 33 cycles and ex_we=0 throughout. Then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Following MFHI with wd=5 returns 0xFFFFFFFF.
4. DIVU: reg1=0xFFFFFFFF, reg2=0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF after 33 stall cycles. Back-to-back DIVU 100/7 -> lo_o=14, hi_o=2.
5. Divide-by-zero: DIV reg1=0x1234, reg2=0 -> stallreq for 1 cycle, then hi_o=0x1234, lo_o=0xFFFFFFFF.
6. Reset mid-divide: assert rst=0 at RUN counter=10 -> next cycle stallreq=0, hi_o=lo_o=0. A new DIV 9/3 after release gives lo_o=3, hi_o=0.
